// File: rtl/jtframe_sndrec_mc.sv
// jtframe_sndrec_mc: records sound-chip register writes and sync ticks into an
// on-chip byte stream with run-length compressed silence, read back via ioctl.
module jtframe_sndrec_mc #(
    parameter int CH    = 2,
    parameter int AW    = 4,
    parameter int RECAW = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rec_en,
    input  logic             tick,
    input  logic [CH-1:0]    we,
    input  logic [CH*AW-1:0] addr,
    input  logic [CH*8-1:0]  din,
    input  logic [RECAW-1:0] ioctl_addr,
    output logic [7:0]       ioctl_din,
    output logic [RECAW-1:0] rec_addr,
    output logic             busy,
    output logic             full,
    output logic             ovf
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [RECAW-1:0] LAST     = '1;
    localparam logic [RECAW-1:0] TICK_MAX = RECAW'(2**RECAW - 2);
    localparam logic [RECAW-1:0] EVT_MAX  = RECAW'(2**RECAW - 4);

    typedef enum logic [2:0] {
        ST_CLEAR, ST_IDLE, ST_RUN, ST_HDR, ST_ADR, ST_DAT, ST_FULL
    } state_t;

    state_t           state_q, state_d;
    logic [RECAW-1:0] clr_q, clr_d, rec_addr_q, rec_addr_d;
    logic             full_q, full_d, ovf_q, ovf_d, tick_q;
    logic [CH-1:0]    we_q, pend_q, pend_d, we_edge;
    logic [6:0]       run_q, run_d;
    logic [7:0]       tbyte_q, tbyte_d;
    logic [SW-1:0]    sel_q, sel_d, low_pend;
    logic [AW-1:0]    lat_a_q [CH];
    logic [7:0]       lat_d_q [CH];
    logic [7:0]       mem_q [2**RECAW];
    logic             cap, tick_edge, mem_we;
    logic [RECAW-1:0] mem_wa;
    logic [7:0]       mem_wd;

    assign we_edge   = we & ~we_q;
    assign tick_edge = tick & ~tick_q;
    assign cap       = (state_q != ST_CLEAR) && !full_q && rec_en;

    assign rec_addr = rec_addr_q;
    assign busy     = (state_q == ST_CLEAR);
    assign full     = full_q;
    assign ovf      = ovf_q;

    always_comb begin
        low_pend = '0;
        for (int i = CH - 1; i >= 0; i--)
            if (pend_q[i]) low_pend = SW'(i);
    end

    always_comb begin
        state_d    = state_q;
        clr_d      = clr_q;
        rec_addr_d = rec_addr_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        pend_d     = pend_q;
        run_d      = run_q;
        tbyte_d    = tbyte_q;
        sel_d      = sel_q;
        mem_we     = 1'b0;
        mem_wa     = rec_addr_q;
        mem_wd     = 8'h00;

        if (cap) begin
            for (int i = 0; i < CH; i++)
                if (we_edge[i]) begin
                    if (pend_q[i]) ovf_d = 1'b1;
                    else           pend_d[i] = 1'b1;
                end
            // Saturate only if the flush cannot happen this cycle (mid-event)
            if (tick_edge && run_q != 7'd127) run_d = run_q + 7'd1;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_q;
                clr_d  = clr_q + RECAW'(1);
                if (clr_q == LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rec_en && run_q != 7'd0 && (|pend_q || run_q == 7'd127)) begin
                    if (rec_addr_q <= TICK_MAX) begin
                        tbyte_d = {1'b1, run_q};
                        run_d   = (cap && tick_edge) ? 7'd1 : 7'd0;
                        state_d = ST_RUN;
                    end else begin
                        full_d  = 1'b1;
                        state_d = ST_FULL;
                    end
                end else if (|pend_q) begin
                    if (rec_addr_q <= EVT_MAX) begin
                        sel_d   = low_pend;
                        state_d = ST_HDR;
                    end else begin
                        full_d  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
            end
            ST_RUN: begin
                mem_we     = 1'b1;
                mem_wd     = tbyte_q;
                rec_addr_d = rec_addr_q + RECAW'(1);
                state_d    = ST_IDLE;
            end
            ST_HDR: begin
                mem_we     = 1'b1;
                mem_wd     = 8'h40 | 8'(sel_q);
                rec_addr_d = rec_addr_q + RECAW'(1);
                state_d    = ST_ADR;
            end
            ST_ADR: begin
                mem_we     = 1'b1;
                mem_wd     = 8'(lat_a_q[sel_q]);
                rec_addr_d = rec_addr_q + RECAW'(1);
                state_d    = ST_DAT;
            end
            ST_DAT: begin
                mem_we         = 1'b1;
                mem_wd         = lat_d_q[sel_q];
                rec_addr_d     = rec_addr_q + RECAW'(1);
                pend_d[sel_q]  = 1'b0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_FULL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_q      <= '0;
            rec_addr_q <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            pend_q     <= '0;
            run_q      <= 7'd0;
            we_q       <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            rec_addr_q <= rec_addr_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            run_q      <= run_d;
            we_q       <= we;
            tick_q     <= tick;
        end
    end

    // Holding registers load only when the edge is accepted, so a dropped
    // write never corrupts the one still waiting to be serialised.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++)
            if (cap && we_edge[i] && !pend_q[i]) begin
                lat_a_q[i] <= addr[i*AW +: AW];
                lat_d_q[i] <= din[i*8 +: 8];
            end
        tbyte_q <= tbyte_d;
        sel_q   <= sel_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
        ioctl_din <= mem_q[ioctl_addr];
    end
endmodule

// File: tb/tb_jtframe_sndrec_mc.sv
// Bench for jtframe_sndrec_mc: directed and random stimulus compared against a
// stream-level model (tick counting and event bytes) held in a queue.
module tb_jtframe_sndrec_mc;
    localparam int CH  = 2;
    localparam int AW  = 4;
    localparam int BAW = 8;
    localparam int SAW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rec_en = 1'b0;
    logic tick = 1'b0;
    logic tick_s = 1'b0;
    logic [CH-1:0]    we = '0, we_s = '0;
    logic [CH*AW-1:0] addr = '0, addr_s = '0;
    logic [CH*8-1:0]  din = '0, din_s = '0;
    logic [BAW-1:0]   io_a = '0, rec_a;
    logic [SAW-1:0]   io_as = '0, rec_as;
    logic [7:0]       io_d, io_ds;
    logic busy, full, ovf, busy_s, full_s, ovf_s;

    int n_pass = 0, n_chk = 0, n_fail = 0;
    byte unsigned exp_q[$];
    byte unsigned exp_s[$];
    int run_m = 0;

    jtframe_sndrec_mc #(.CH(CH), .AW(AW), .RECAW(BAW)) u_big (
        .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .tick(tick), .we(we),
        .addr(addr), .din(din), .ioctl_addr(io_a), .ioctl_din(io_d),
        .rec_addr(rec_a), .busy(busy), .full(full), .ovf(ovf));

    jtframe_sndrec_mc #(.CH(CH), .AW(AW), .RECAW(SAW)) u_small (
        .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .tick(tick_s), .we(we_s),
        .addr(addr_s), .din(din_s), .ioctl_addr(io_as), .ioctl_din(io_ds),
        .rec_addr(rec_as), .busy(busy_s), .full(full_s), .ovf(ovf_s));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stream-level reference: ticks accumulate, 127 flushes on its own,
    // any write flushes pending ticks ahead of its 3-byte event.
    function automatic void m_tick();
        run_m++;
        if (run_m == 127) begin
            exp_q.push_back(8'hFF);
            run_m = 0;
        end
    endfunction

    function automatic void m_write(input int ch, input int a, input int d);
        if (run_m > 0) begin
            exp_q.push_back(byte'(8'h80 | run_m));
            run_m = 0;
        end
        exp_q.push_back(byte'(8'h40 | ch));
        exp_q.push_back(byte'(a));
        exp_q.push_back(byte'(d));
    endfunction

    task automatic do_tick();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
    endtask

    task automatic do_write(input int ch, input int a, input int d);
        addr[ch*AW +: AW] = AW'(a);
        din[ch*8 +: 8]    = 8'(d);
        we[ch] = 1'b1; cyc();
        we[ch] = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic do_write_s(input int a, input int d);
        addr_s[0 +: AW] = AW'(a);
        din_s[0 +: 8]   = 8'(d);
        we_s[0] = 1'b1; cyc();
        we_s[0] = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic rd_big(input int a, output logic [7:0] v);
        io_a = BAW'(a); cyc();
        v = io_d;
    endtask

    task automatic rd_small(input int a, output logic [7:0] v);
        io_as = SAW'(a); cyc();
        v = io_ds;
    endtask

    initial begin
        logic [7:0] v;
        int t_b, t_s, nbad, base, r;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", busy, 1);
        chk("rst_rec_addr", rec_a, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);

        // Clear phase length on both sizes
        rst_n = 1'b1;
        t_b = -1; t_s = -1;
        for (int c = 1; c <= 400 && t_b < 0; c++) begin
            cyc();
            if (!busy_s && t_s < 0) t_s = c;
            if (!busy && t_b < 0) t_b = c;
        end
        chk("clear_cycles_small", t_s, 16);
        chk("clear_cycles_big", t_b, 256);
        chk("clear_rec_addr", rec_a, 0);
        nbad = 0;
        for (int i = 0; i < 256; i++) begin
            rd_big(i, v);
            if (v !== 8'h00) nbad++;
        end
        chk("clear_bytes_big", nbad, 0);
        for (int i = 0; i < 16; i++) begin
            rd_small(i, v);
            chk($sformatf("clear_small[%0d]", i), v, 0);
        end

        rec_en = 1'b1;
        cyc();

        // Single write ch1 03/A5
        do_write(1, 3, 8'hA5); m_write(1, 3, 8'hA5);
        chk("single_rec_addr", rec_a, 3);
        chk("single_ovf", ovf, 0);

        // Five ticks then ch0 02/7F
        repeat (5) begin do_tick(); m_tick(); end
        repeat (4) cyc();
        chk("ticks_held", rec_a, 3);
        do_write(0, 2, 8'h7F); m_write(0, 2, 8'h7F);
        chk("silence_rec_addr", rec_a, exp_q.size());

        // 130 ticks: FF emitted alone, 3 held
        base = rec_a;
        for (int i = 0; i < 130; i++) begin do_tick(); m_tick(); end
        repeat (6) cyc();
        chk("sat_one_byte", rec_a, base + 1);
        do_write(1, 12, 8'h11); m_write(1, 12, 8'h11);
        chk("sat_rec_addr", rec_a, exp_q.size());

        // Simultaneous edges: ch0 first, then ch1
        addr[0 +: AW] = 4'd1; din[0 +: 8] = 8'h10;
        addr[AW +: AW] = 4'd2; din[8 +: 8] = 8'h20;
        we = 2'b11; cyc();
        we = 2'b00;
        repeat (12) cyc();
        m_write(0, 1, 8'h10); m_write(1, 2, 8'h20);
        chk("simul_rec_addr", rec_a, exp_q.size());
        chk("simul_ovf", ovf, 0);

        // Second ch0 edge before DAT is dropped
        addr[0 +: AW] = 4'd5; din[0 +: 8] = 8'h55;
        we[0] = 1'b1; cyc();
        we[0] = 1'b0; cyc();
        addr[0 +: AW] = 4'd6; din[0 +: 8] = 8'h66;
        we[0] = 1'b1; cyc();
        we[0] = 1'b0;
        repeat (10) cyc();
        m_write(0, 5, 8'h55);
        chk("ovf_set", ovf, 1);
        chk("ovf_rec_addr", rec_a, exp_q.size());

        // Pause: run held, ticks/writes ignored, held-high we gives no edge
        repeat (4) begin do_tick(); m_tick(); end
        rec_en = 1'b0;
        repeat (3) do_tick();
        do_write(0, 7, 8'h77);
        we[1] = 1'b1; cyc();
        rec_en = 1'b1;
        repeat (4) cyc();
        we[1] = 1'b0;
        repeat (4) cyc();
        chk("pause_rec_addr", rec_a, exp_q.size());
        do_write(1, 9, 8'h99); m_write(1, 9, 8'h99);
        chk("resume_rec_addr", rec_a, exp_q.size());

        // Random mix of writes and tick bursts
        for (int s = 0; s < 40; s++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                repeat ($urandom_range(1, 20)) begin do_tick(); m_tick(); end
                repeat (4) cyc();
            end else begin
                int ch, a, d;
                ch = $urandom_range(0, 1);
                a  = $urandom_range(0, 15);
                d  = $urandom_range(0, 255);
                do_write(ch, a, d); m_write(ch, a, d);
            end
            chk($sformatf("rand_rec_addr[%0d]", s), rec_a, exp_q.size());
        end
        chk("big_full", full, 0);

        // Whole stream readback, plus EOF bytes after it
        for (int i = 0; i < exp_q.size() + 2; i++) begin
            rd_big(i, v);
            chk($sformatf("stream[%0d]", i), v, (i < exp_q.size()) ? exp_q[i] : 8'h00);
        end

        // Full on the 16-byte instance
        for (int e = 0; e < 4; e++) begin
            do_write_s(e + 1, 8'hC0 + e);
            exp_s.push_back(8'h40); exp_s.push_back(byte'(e + 1)); exp_s.push_back(byte'(8'hC0 + e));
        end
        chk("full_after4_addr", rec_as, 12);
        chk("full_after4_flag", full_s, 0);
        do_write_s(14, 8'hC4);
        exp_s.push_back(8'h40); exp_s.push_back(8'd14); exp_s.push_back(8'hC4);
        chk("full_after5_addr", rec_as, 15);
        chk("full_after5_flag", full_s, 0);
        do_write_s(15, 8'hC5);
        chk("full_set", full_s, 1);
        chk("full_addr_stop", rec_as, 15);
        do_write_s(3, 8'h33);
        chk("full_ignored", rec_as, 15);
        for (int i = 0; i < 16; i++) begin
            rd_small(i, v);
            chk($sformatf("small[%0d]", i), v, (i < exp_s.size()) ? exp_s[i] : 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
